// File: rtl/align_pp_sched_if.sv
// Handshake and aligner-side signal bundle for align_pp_sched.
interface align_pp_sched_if #(
    parameter int unsigned PP_W    = 4,
    parameter int unsigned EXP_W   = 6,
    parameter int unsigned ALIGN_W = 15,
    parameter int unsigned ACC_W   = 17
);
    logic               in_valid;
    logic               in_ready;
    logic [PP_W-1:0]    in_denorm_pp;
    logic [EXP_W-1:0]   in_exp;

    logic [PP_W-1:0]    al_denorm_pp;
    logic [EXP_W-1:0]   al_exp;
    logic [EXP_W-1:0]   al_max_exp;
    logic [ALIGN_W-1:0] al_align_pp;

    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [EXP_W-1:0]   out_max_exp;
    logic               busy;

    // Sequencer view.
    modport slave (
        input  in_valid, in_denorm_pp, in_exp, al_align_pp, out_ready,
        output in_ready, al_denorm_pp, al_exp, al_max_exp,
               out_valid, out_sum, out_max_exp, busy
    );

    // Producer / consumer / aligner view.
    modport master (
        output in_valid, in_denorm_pp, in_exp, al_align_pp, out_ready,
        input  in_ready, al_denorm_pp, al_exp, al_max_exp,
               out_valid, out_sum, out_max_exp, busy
    );
endinterface

// File: rtl/align_pp_sched.sv
// Time-shares one external combinational aligner across a group of N_PP
// partial products: LOAD collects the group and tracks its max exponent,
// ALIGN feeds one product per cycle and accumulates, DONE presents the sum.
module align_pp_sched #(
    parameter int unsigned N_PP    = 4,
    parameter int unsigned PP_W    = 4,
    parameter int unsigned EXP_W   = 6,
    parameter int unsigned ALIGN_W = 15,
    parameter int unsigned ACC_W   = ALIGN_W + $clog2(N_PP)
) (
    input  logic clk,
    input  logic rst_n,
    align_pp_sched_if.slave bus
);

    localparam int unsigned IDX_W = (N_PP > 1) ? $clog2(N_PP) : 1;
    localparam int unsigned EXT_W = ACC_W - ALIGN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PP - 1);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [EXP_W-1:0] max_q, max_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wr_en;

    logic [PP_W-1:0]  pp_buf  [N_PP];
    logic [EXP_W-1:0] exp_buf [N_PP];

    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [PP_W-1:0]  al_pp_q, al_pp_d;
    logic [EXP_W-1:0] al_exp_q, al_exp_d;
    logic [EXP_W-1:0] al_max_q, al_max_d;

    logic             accept;
    logic [ACC_W-1:0] align_ext;

    assign accept    = bus.in_valid && in_ready_q;
    assign align_ext = {{EXT_W{bus.al_align_pp[ALIGN_W-1]}}, bus.al_align_pp};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        max_d       = max_q;
        acc_d       = acc_q;
        wr_en       = 1'b0;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        al_pp_d     = '0;
        al_exp_d    = '0;
        al_max_d    = '0;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    // First entry of a group restarts the max search.
                    if ((cnt_q == '0) || (bus.in_exp > max_q)) begin
                        max_d = bus.in_exp;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = S_ALIGN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ALIGN: begin
                acc_d = acc_q + align_ext;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_ALIGN) || (state_d == S_DONE);
        out_valid_d = (state_d == S_DONE);

        // Aligner sees a zero product (so returns 0) whenever not aligning.
        al_exp_d = max_d;
        al_max_d = max_d;
        if (state_d == S_ALIGN) begin
            al_pp_d  = pp_buf[idx_d];
            al_exp_d = exp_buf[idx_d];
        end
    end

    // State, counters, max exponent and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            acc_q   <= acc_d;
        end
    end

    // Group buffer, written at the load count on each accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_PP); i++) begin
                pp_buf[i]  <= '0;
                exp_buf[i] <= '0;
            end
        end else if (wr_en) begin
            pp_buf[cnt_q]  <= bus.in_denorm_pp;
            exp_buf[cnt_q] <= bus.in_exp;
        end
    end

    // Registered handshake and aligner-drive outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            al_pp_q     <= '0;
            al_exp_q    <= '0;
            al_max_q    <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            al_pp_q     <= al_pp_d;
            al_exp_q    <= al_exp_d;
            al_max_q    <= al_max_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = acc_q;
    assign bus.out_max_exp  = max_q;
    assign bus.al_denorm_pp = al_pp_q;
    assign bus.al_exp       = al_exp_q;
    assign bus.al_max_exp   = al_max_q;

endmodule
